// File: rtl/distortion_pipe.sv
// distortion_pipe: framed multi-channel distortion through one shared 3-stage shaper.
// Optional clip statistics counter enabled by defining DIST_CLIP_STAT_EN.
module distortion_pipe #(
  parameter int DATA_W     = 16,
  parameter int CHANNELS   = 2,
  parameter int THR_LIGHT  = 20000,
  parameter int THR_NORMAL = 16000,
  parameter int THR_HEAVY  = 12000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 mode,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [CHANNELS*DATA_W-1:0] s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [CHANNELS*DATA_W-1:0] m_data
`ifdef DIST_CLIP_STAT_EN
  ,
  input  logic                       clip_clr,
  output logic [15:0]                clip_cnt
`endif
);

  localparam int ACC_W = DATA_W + 4;
  localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CW-1:0] LAST = CW'(CHANNELS - 1);

  localparam logic [ACC_W-1:0] T_L = ACC_W'(THR_LIGHT);
  localparam logic [ACC_W-1:0] T_N = ACC_W'(THR_NORMAL);
  localparam logic [ACC_W-1:0] T_H = ACC_W'(THR_HEAVY);

  localparam logic signed [ACC_W-1:0] SMAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_OUT
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_accept;
  logic   w_last;

  logic                       r_sready;
  logic                       r_mvalid;
  logic [CHANNELS*DATA_W-1:0] r_frame;
  logic [CHANNELS*DATA_W-1:0] r_mdata;
  logic [1:0]                 r_mode;

  logic [CW-1:0] r_ch;
  logic          r_iss;

  logic             r_v1;
  logic [CW-1:0]    r_ch1;
  logic             r_neg1;
  logic [ACC_W-1:0] r_a1;

  logic             r_v2;
  logic [CW-1:0]    r_ch2;
  logic             r_neg2;
  logic [ACC_W-1:0] r_y2;

  logic [DATA_W-1:0] w_samp;
  logic [ACC_W-1:0]  w_sext;
  logic [ACC_W-1:0]  w_x;
  logic [ACC_W-1:0]  w_a;

  logic [ACC_W-1:0] w_t;
  logic [ACC_W-1:0] w_t2;
  logic [ACC_W-1:0] w_t15;
  logic [ACC_W-1:0] w_y;
  logic             w_knee;

  logic signed [ACC_W-1:0] w_z;
  logic [DATA_W-1:0]       w_out;

  assign s_ready = r_sready;
  assign m_valid = r_mvalid;
  assign m_data  = r_mdata;
  assign w_last  = r_v2 && (r_ch2 == LAST);

  // Frame sequencing: accept, run channels through the pipe, present result
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (s_valid && r_sready) begin
          w_accept = 1'b1;
          w_next   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_last) w_next = ST_OUT;
      end
      ST_OUT: begin
        if (m_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State register with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_sready <= 1'b0;
      r_mvalid <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_sready <= (w_next == ST_IDLE);
      r_mvalid <= (w_next == ST_OUT);
    end
  end

  // Latch the frame and its mode on accept so the whole frame shares one mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame <= '0;
      r_mode  <= 2'b00;
    end else if (w_accept) begin
      r_frame <= s_data;
      r_mode  <= mode;
    end
  end

  // Channel issue counter: one channel per cycle after accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch  <= '0;
      r_iss <= 1'b0;
    end else if (w_accept) begin
      r_ch  <= '0;
      r_iss <= 1'b1;
    end else if (r_iss) begin
      if (r_ch == LAST) r_iss <= 1'b0;
      else              r_ch  <= r_ch + 1'b1;
    end
  end

  // S1 combinational: select channel, apply gain, take magnitude
  always_comb begin
    w_samp = r_frame[int'(r_ch)*DATA_W +: DATA_W];
    w_sext = {{(ACC_W-DATA_W){w_samp[DATA_W-1]}}, w_samp};
    w_x    = w_sext;
    unique case (r_mode)
      2'b00:   w_x = w_sext;
      2'b01:   w_x = w_sext << 1;
      2'b10:   w_x = w_sext << 2;
      2'b11:   w_x = w_sext << 3;
      default: w_x = w_sext;
    endcase
    w_a = w_x[ACC_W-1] ? (~w_x + 1'b1) : w_x;
  end

  // S1 register: sign and unsigned magnitude of the gained sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_ch1  <= '0;
      r_neg1 <= 1'b0;
      r_a1   <= '0;
    end else begin
      r_v1 <= r_iss;
      if (r_iss) begin
        r_ch1  <= r_ch;
        r_neg1 <= w_x[ACC_W-1];
        r_a1   <= w_a;
      end
    end
  end

  // S2 combinational: three-segment soft knee on the magnitude
  always_comb begin
    w_t    = '0;
    w_y    = r_a1;
    w_knee = 1'b0;
    unique case (r_mode)
      2'b01:   w_t = T_L;
      2'b10:   w_t = T_N;
      2'b11:   w_t = T_H;
      default: w_t = '0;
    endcase
    w_t2  = w_t << 1;
    w_t15 = w_t + (w_t >> 1);
    if (r_mode != 2'b00) begin
      if (r_a1 > w_t2) begin
        w_y    = w_t15 + ((r_a1 - w_t2) >> 2);
        w_knee = 1'b1;
      end else if (r_a1 > w_t) begin
        w_y = w_t + ((r_a1 - w_t) >> 1);
      end
    end
  end

  // S2 register: shaped magnitude
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2   <= 1'b0;
      r_ch2  <= '0;
      r_neg2 <= 1'b0;
      r_y2   <= '0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_ch2  <= r_ch1;
        r_neg2 <= r_neg1;
        r_y2   <= w_y;
      end
    end
  end

  // S3 combinational: restore sign and clamp to the sample range
  always_comb begin
    w_z   = r_neg2 ? $signed(~r_y2 + 1'b1) : $signed(r_y2);
    w_out = w_z[DATA_W-1:0];
    if (w_z > SMAX)      w_out = SMAX[DATA_W-1:0];
    else if (w_z < SMIN) w_out = SMIN[DATA_W-1:0];
  end

  // S3 register: write the finished channel into its output slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mdata <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (r_v2 && (r_ch2 == CW'(c)))
          r_mdata[c*DATA_W +: DATA_W] <= w_out;
      end
    end
  end

`ifdef DIST_CLIP_STAT_EN
  logic        r_knee2;
  logic        w_sat_hit;
  logic [15:0] r_clip_cnt;

  assign w_sat_hit = (w_z > SMAX) || (w_z < SMIN);
  assign clip_cnt  = r_clip_cnt;

  // Carry the hard-knee flag alongside the S2 result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_knee2 <= 1'b0;
    else if (r_v1) r_knee2 <= w_knee;
  end

  // Count clipped samples, saturating; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clip_cnt <= '0;
    end else if (clip_clr) begin
      r_clip_cnt <= '0;
    end else if (r_v2 && (r_knee2 || w_sat_hit) &&
                 (r_clip_cnt != 16'hFFFF)) begin
      r_clip_cnt <= r_clip_cnt + 16'd1;
    end
  end
`else
  logic w_knee_unused;
  assign w_knee_unused = w_knee;
`endif

endmodule

// File: tb/tb_distortion_pipe.sv
// tb_distortion_pipe: directed vectors and corner sequences for distortion_pipe.
// Clip counter checks apply when DIST_CLIP_STAT_EN is defined.
module tb_distortion_pipe;

  logic        clk;
  logic        rst_n;
  logic [1:0]  mode;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
`ifdef DIST_CLIP_STAT_EN
  logic        clip_clr;
  logic [15:0] clip_cnt;
  int          exp_clip;
`endif

  int checks;
  int errors;

  distortion_pipe dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .mode    (mode),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data)
`ifdef DIST_CLIP_STAT_EN
    ,
    .clip_clr(clip_clr),
    .clip_cnt(clip_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  md;
    logic [15:0] c0;
    logic [15:0] c1;
    logic [15:0] e0;
    logic [15:0] e1;
    int          clip;
  } vec_t;

  vec_t tv[10];

  function automatic vec_t mk(input logic [1:0] m, input int a, input int b,
                              input int x, input int y, input int k);
    vec_t v;
    v.md   = m;
    v.c0   = 16'(a);
    v.c1   = 16'(b);
    v.e0   = 16'(x);
    v.e1   = 16'(y);
    v.clip = k;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  task automatic send(input logic [1:0] md, input int c0, input int c1);
    int n;
    mode    = md;
    s_data  = {16'(c1), 16'(c0)};
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat, output logic sr_seen);
    lat     = 0;
    sr_seen = 1'b0;
    while (!m_valid && lat < 30) begin
      if (s_ready) sr_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (!m_valid) chk("out_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int          lat;
    logic        sr;
    logic        stable;
    logic        mv_all;
    logic        mv_seen;
    logic [31:0] held;

    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    mode    = 2'b00;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b1;
`ifdef DIST_CLIP_STAT_EN
    clip_clr = 1'b0;
    exp_clip = 0;
`endif

    tv[0] = mk(2'b01,  15000, -15000,  25000, -25000, 0);
    tv[1] = mk(2'b11,  32767, -32768,  32767, -32768, 2);
    tv[2] = mk(2'b10,   3000,  -3000,  12000, -12000, 0);
    tv[3] = mk(2'b00, -32768,      1, -32768,      1, 0);
    tv[4] = mk(2'b01,  32767,     -1,  32767,     -2, 1);
    tv[5] = mk(2'b10,  10000,  -5000,  26000, -18000, 1);
    tv[6] = mk(2'b11,   1500,  -2000,  12000, -14000, 0);
    tv[7] = mk(2'b01,     -7,  20001,    -14,  30000, 1);
    tv[8] = mk(2'b01,  10001, -10001,  20001, -20001, 0);
    tv[9] = mk(2'b11,   3001,  -3001,  18002, -18002, 2);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_data", m_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_s_ready_low", {31'd0, s_ready}, 32'd0);
    @(posedge clk); #1;
    chk("rel_s_ready_up", {31'd0, s_ready}, 32'd1);

    for (int i = 0; i < 10; i++) begin
      send(tv[i].md, int'($signed(tv[i].c0)), int'($signed(tv[i].c1)));
      wait_out(lat, sr);
      chk($sformatf("v%0d_lat", i), lat, 32'd4);
      chk($sformatf("v%0d_sready_busy", i), {31'd0, sr}, 32'd0);
      chk($sformatf("v%0d_ch0", i), {16'd0, m_data[15:0]},
          {16'd0, tv[i].e0});
      chk($sformatf("v%0d_ch1", i), {16'd0, m_data[31:16]},
          {16'd0, tv[i].e1});
`ifdef DIST_CLIP_STAT_EN
      exp_clip += tv[i].clip;
      chk($sformatf("v%0d_clip", i), {16'd0, clip_cnt}, 32'(exp_clip));
`endif
      @(posedge clk); #1;
      chk($sformatf("v%0d_mv_drop", i), {31'd0, m_valid}, 32'd0);
      chk($sformatf("v%0d_sr_up", i), {31'd0, s_ready}, 32'd1);
    end

    m_ready = 1'b0;
    send(2'b10, 3000, -3000);
    wait_out(lat, sr);
    held = m_data;
    chk("bp_data", held, {16'(-12000), 16'd12000});
    mode    = 2'b01;
    s_data  = {16'(-1000), 16'd1000};
    s_valid = 1'b1;
    stable  = 1'b1;
    mv_all  = 1'b1;
    sr      = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (m_data !== held) stable = 1'b0;
      if (s_ready)         sr     = 1'b1;
      if (!m_valid)        mv_all = 1'b0;
    end
    chk("bp_stable", {31'd0, stable}, 32'd1);
    chk("bp_sready", {31'd0, sr}, 32'd0);
    chk("bp_mvalid", {31'd0, mv_all}, 32'd1);
    m_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_hs_mv", {31'd0, m_valid}, 32'd0);
    chk("bp_hs_sr", {31'd0, s_ready}, 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    wait_out(lat, sr);
    chk("bp_next_lat", lat, 32'd4);
    chk("bp_next_data", m_data, {16'(-2000), 16'd2000});
    @(posedge clk); #1;

    send(2'b01, 15000, -15000);
    @(posedge clk); #1;
    mode = 2'b11;
    wait_out(lat, sr);
    chk("tog_first", m_data, {16'(-25000), 16'd25000});
    @(posedge clk); #1;
    send(2'b11, 1500, -2000);
    wait_out(lat, sr);
    chk("tog_second", m_data, {16'(-14000), 16'd12000});
    @(posedge clk); #1;

    send(2'b01, 15000, -15000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("mrst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("mrst_m_data", m_data, 32'd0);
`ifdef DIST_CLIP_STAT_EN
    exp_clip = 0;
    chk("mrst_clip", {16'd0, clip_cnt}, 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    mv_seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (m_valid) mv_seen = 1'b1;
    end
    chk("mrst_no_stale", {31'd0, mv_seen}, 32'd0);
    send(2'b10, 10000, -5000);
    wait_out(lat, sr);
    chk("mrst_lat", lat, 32'd4);
    chk("mrst_data", m_data, {16'(-18000), 16'd26000});
`ifdef DIST_CLIP_STAT_EN
    chk("mrst_clip_after", {16'd0, clip_cnt}, 32'd1);
`endif
    @(posedge clk); #1;

`ifdef DIST_CLIP_STAT_EN
    clip_clr = 1'b1;
    @(posedge clk); #1;
    clip_clr = 1'b0;
    chk("clip_clr", {16'd0, clip_cnt}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
